// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared helpers for the matrix multiplier
package matmul_pkg;

   localparam int DEFAULT_N     = 4;
   localparam int DEFAULT_WIDTH = 8;

   // Number of registered adder levels needed to reduce n terms
   function automatic int stage_count(input int n);
      return $clog2(n);
   endfunction

   localparam int DEFAULT_STAGES = stage_count(DEFAULT_N);

   // Bit offset of element [i][j] in a flat row-major matrix bus
   function automatic int elem_lsb(input int i, input int j, input int n, input int w);
      return (i * n + j) * w;
   endfunction

endpackage

// File: rtl/matmul_if.sv
// rtl/matmul_if.sv - flat matrix operand/result bundle
interface matmul_if #(
   parameter int N     = 4,
   parameter int WIDTH = 8
);
   logic [N*N*WIDTH-1:0] A_flat;
   logic [N*N*WIDTH-1:0] B_flat;
   logic [N*N*WIDTH-1:0] C_flat;

   modport master (output A_flat, output B_flat, input C_flat);
   modport slave  (input A_flat, input B_flat, output C_flat);
endinterface

// File: rtl/matmul_adder_tree.sv
// rtl/matmul_adder_tree.sv - registered binary reduction tree, one register per level
module adder_tree
   import matmul_pkg::*;
#(
   parameter int NIN   = 4,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NIN*WIDTH-1:0] terms,
   output logic [WIDTH-1:0]   sum
);

   localparam int STAGES = stage_count(NIN);
   localparam int NNODE  = 2 * NIN - 1;

   // All level outputs packed back to back: level s writes NIN>>(s+1) entries
   // starting at 2*NIN - 2*(NIN>>(s+1)) - NIN; the final sum is the last entry.
   logic [WIDTH-1:0] sum_q [NIN-1];

   // node[0..NIN-1] are the raw terms, node[NIN..] mirror sum_q, so every level
   // reads its operands from node[] without special-casing the first level.
   logic [WIDTH-1:0] node  [NNODE];

   // Flatten terms and registered partial sums into one operand array
   always_comb begin
      for (int k = 0; k < NNODE; k++) begin
         node[k] = '0;
      end
      for (int k = 0; k < NIN; k++) begin
         node[k] = terms[k*WIDTH +: WIDTH];
      end
      for (int k = 0; k < NIN - 1; k++) begin
         node[NIN + k] = sum_q[k];
      end
   end

   // Pairwise add each level into the next; reset flushes every level
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NIN - 1; k++) begin
            sum_q[k] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            for (int k = 0; k < NIN / 2; k++) begin
               if (k < (NIN >> (s + 1))) begin
                  sum_q[NIN - 2 * (NIN >> (s + 1)) + k] <=
                     node[2 * NIN - 2 * (NIN >> s) + 2 * k] +
                     node[2 * NIN - 2 * (NIN >> s) + 2 * k + 1];
               end
            end
         end
      end
   end

   assign sum = sum_q[NIN-2];

endmodule

// File: rtl/matmul_top.sv
// rtl/matmul_top.sv - pipelined N x N modular matrix multiplier
module matmul_top
   import matmul_pkg::*;
#(
   parameter int N     = DEFAULT_N,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   matmul_if.slave bus
);

   logic [N*N*WIDTH-1:0] c_all;

   // One product row and one reduction tree per output element
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [N*WIDTH-1:0] terms;

         // Products are truncated to WIDTH: the sum is modulo 2^WIDTH anyway
         for (genvar k = 0; k < N; k++) begin : g_prod
            localparam int A_LSB = elem_lsb(i, k, N, WIDTH);
            localparam int B_LSB = elem_lsb(k, j, N, WIDTH);
            assign terms[k*WIDTH +: WIDTH] =
               WIDTH'(bus.A_flat[A_LSB +: WIDTH] * bus.B_flat[B_LSB +: WIDTH]);
         end

         localparam int C_LSB = elem_lsb(i, j, N, WIDTH);

         adder_tree #(
            .NIN   (N),
            .WIDTH (WIDTH)
         ) u_tree (
            .clk   (clk),
            .rst   (rst),
            .terms (terms),
            .sum   (c_all[C_LSB +: WIDTH])
         );
      end
   end

   assign bus.C_flat = c_all;

endmodule

// File: tb/tb_matmul_top.sv
// tb/tb_matmul_top.sv - directed self-checking bench for matmul_top
module tb_matmul_top;

   logic clk;
   logic rst;

   matmul_if #(.N(4), .WIDTH(8))  bus4 ();
   matmul_if #(.N(2), .WIDTH(16)) bus2 ();

   matmul_top #(.N(4), .WIDTH(8)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   matmul_top #(.N(2), .WIDTH(16)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] el4(input logic [127:0] m, input int i, input int j);
      return m[(i*4+j)*8 +: 8];
   endfunction

   // Reference product for the 4x4 / 8-bit instance, accumulated mod 256
   function automatic logic [127:0] model4(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] r;
      logic [15:0]  acc;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
               acc = acc + 16'(el4(a, i, k)) * 16'(el4(b, k, j));
            end
            r[(i*4+j)*8 +: 8] = acc[7:0];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] rand4();
      logic [127:0] r;
      for (int e = 0; e < 16; e++) begin
         r[e*8 +: 8] = 8'($urandom_range(0, 10));
      end
      return r;
   endfunction

   logic [127:0] a_v, b_v, exp_v;
   logic [127:0] hist_a [$];
   logic [127:0] hist_b [$];
   logic [127:0] ra, rb;

   initial begin
      rst = 1'b1;
      bus4.A_flat = '0;
      bus4.B_flat = '0;
      bus2.A_flat = '0;
      bus2.B_flat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_c4", 128'(bus4.C_flat), 128'd0);
      check("reset_c2", 128'(bus2.C_flat), 128'd0);
      rst = 1'b0;

      // A[i][j] = i*4+j, B all ones -> each row holds its row sum
      for (int e = 0; e < 16; e++) begin
         a_v[e*8 +: 8] = 8'(e);
         b_v[e*8 +: 8] = 8'd1;
      end
      bus4.A_flat = a_v;
      bus4.B_flat = b_v;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ones_c00", 128'(el4(bus4.C_flat, 0, 0)), 128'd6);
      check("ones_c13", 128'(el4(bus4.C_flat, 1, 3)), 128'd22);
      check("ones_c21", 128'(el4(bus4.C_flat, 2, 1)), 128'd38);
      check("ones_c32", 128'(el4(bus4.C_flat, 3, 2)), 128'd54);
      exp_v = {{4{8'd54}}, {4{8'd38}}, {4{8'd22}}, {4{8'd6}}};
      check("ones_flat", 128'(bus4.C_flat), exp_v);

      // Identity B -> C equals A
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            b_v[(k*4+j)*8 +: 8] = (k == j) ? 8'd1 : 8'd0;
         end
      end
      bus4.B_flat = b_v;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ident_c33", 128'(el4(bus4.C_flat, 3, 3)), 128'd15);
      check("ident_c12", 128'(el4(bus4.C_flat, 1, 2)), 128'd6);
      check("ident_flat", 128'(bus4.C_flat), a_v);

      // Overflow: 255*255 = 1 mod 256, four terms -> 4
      bus4.A_flat = {16{8'd255}};
      bus4.B_flat = {16{8'd255}};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ovf_255", 128'(bus4.C_flat), {16{8'd4}});

      // 16*16 = 256 -> 0 mod 256
      bus4.A_flat = {16{8'd16}};
      bus4.B_flat = {16{8'd16}};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ovf_16", 128'(bus4.C_flat), 128'd0);

      // N=2, WIDTH=16: [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]] after 1 edge
      bus2.A_flat = {16'd4, 16'd3, 16'd2, 16'd1};
      bus2.B_flat = {16'd8, 16'd7, 16'd6, 16'd5};
      @(posedge clk);
      @(negedge clk);
      check("n2_prod", 128'(bus2.C_flat), 128'({16'd50, 16'd43, 16'd22, 16'd19}));

      // Back-to-back stream: new operands every cycle, output lags by two edges
      hist_a.delete();
      hist_b.delete();
      for (int c = 0; c < 22; c++) begin
         if (c >= 2) begin
            check($sformatf("stream_%0d", c), 128'(bus4.C_flat),
                  model4(hist_a[c-2], hist_b[c-2]));
         end
         ra = rand4();
         rb = rand4();
         hist_a.push_back(ra);
         hist_b.push_back(rb);
         bus4.A_flat = ra;
         bus4.B_flat = rb;
         @(negedge clk);
      end

      // Mid-stream reset for one edge discards everything in flight
      rst = 1'b1;
      bus4.A_flat = rand4();
      bus4.B_flat = rand4();
      @(negedge clk);
      check("midrst_zero", 128'(bus4.C_flat), 128'd0);
      rst = 1'b0;
      hist_a.delete();
      hist_b.delete();
      for (int c = 0; c < 5; c++) begin
         if (c >= 2) begin
            check($sformatf("postrst_%0d", c), 128'(bus4.C_flat),
                  model4(hist_a[c-2], hist_b[c-2]));
         end
         ra = rand4();
         rb = rand4();
         hist_a.push_back(ra);
         hist_b.push_back(rb);
         bus4.A_flat = ra;
         bus4.B_flat = rb;
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_top.md
Name: matmul_top

Overview:
Fully pipelined, parameterised square matrix multiplier that computes C = A x B for N x N unsigned matrices of WIDTH-bit elements. Matrices enter and leave as flat packed buses. Inputs are combinational; each output element is reduced through a registered binary adder tree. The block accepts a new A/B pair every clock cycle and produces the product log2(N) cycles later.

Parameters:
N, 4, matrix dimension; must be a power of two and at least 2.
WIDTH, 8, bit width of every element of A, B and C (unsigned).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
A_flat  input  N*N*WIDTH  matrix A; element [i][j] at bits (i*N+j)*WIDTH +: WIDTH
B_flat  input  N*N*WIDTH  matrix B; same layout as A_flat
C_flat  output  N*N*WIDTH  product matrix C; same layout, registered

Behaviour:
- Single clock domain, clk. Reset rst is synchronous and active-high.
- Arithmetic:
  - C[i][j] = sum over k of A[i][k]*B[k][j], modulo 2^WIDTH. The result is truncated to WIDTH bits; there is no saturation and no overflow flag.
  - Internal products and partial sums may be kept at WIDTH bits, since modular arithmetic makes the truncated result identical.
- Datapath per element (i,j):
  - N combinational products A[i][k]*B[k][j].
  - These feed a binary adder tree of log2(N) levels, with a register after every level.
- Latency is exactly log2(N) clock edges. Inputs sampled at edge t appear on C_flat after edge t+log2(N)-1, so C_flat is stable from that edge until the next update. For N=4 the latency is 2 cycles; for N=2 it is 1 cycle.
- Throughput is one matrix pair per cycle. There is no handshake and no valid signal: the bench must hold or advance the inputs itself, and each output corresponds to the inputs present log2(N) edges earlier.
- Reset:
  - When rst=1 at a rising edge, all pipeline registers clear to 0, so C_flat = 0 after that edge.
  - Reset mid-stream discards all in-flight results.
  - After rst deasserts, C_flat is fully valid log2(N) edges after the first non-reset edge. Intermediate cycles may show partial sums.
- Input changes between edges have no effect until the next edge; there is no input register stage.
- The behaviour of X inputs is undefined; the bench must drive known values.

Decomposition:
- Package matmul_pkg holds:
  - a function elem_lsb(i, j, N, WIDTH) that returns (i*N+j)*WIDTH;
  - a localparam helper for the log2(N) stage count.
- One sub-module, adder_tree:
  - parameters NIN and WIDTH; input a flat vector of NIN WIDTH-bit terms; input clk and rst;
  - output the registered sum after log2(NIN) stages, with every stage cleared by rst.
- matmul_top unpacks A and B, forms the products, and instantiates N*N adder_tree copies.
- Expected size is about 150-250 lines of RTL in total.

Test Plan:
1. N=4, WIDTH=8; A[i][j]=i*4+j, B all 1, held -> after 2 edges every column of C equals the row sums: C row0=6, row1=22, row2=38, row3=54.
2. A[i][j]=i*4+j, B = identity -> C equals A after 2 edges (C[3][3]=15, C[1][2]=6).
3. Overflow: A all 255, B all 255 -> each product is 65025 mod 256 = 1, so every C element = 4. Also A all 16, B all 16 -> every C element = 0.
4. Back-to-back stream: 20 consecutive cycles of random A and B with elements in [0,10] -> C_flat at each cycle matches a reference model (mod 256) of the inputs from 2 edges earlier; no bubbles.
5. Reset: assert rst for 1 edge mid-stream -> C_flat = 0 after that edge. After deassert, C_flat matches the model from the 2nd edge onward.
6. Parameter sweep N=2, WIDTH=16; A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]] after 1 edge.
